// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32 multiply/divide unit, one bit per clock.
// Shift-add multiply (MUL, MULHU) and restoring divide (DIV, DIVU, REM, REMU).
// Ports: clk, rst_n (async, active-low); in_valid/in_ready, op, a, b on the
// issue side; out_valid/out_ready, result on the return side; busy.
// Optional macro MDU_ZERO_BYPASS_EN: zero-operand cases skip CALC.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int W = XLEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   dv_q, dv_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic [W-1:0]   res_q, res_d;

  // hi/lo double as product accumulator (mul) or
  // partial remainder / shifting dividend-quotient (div).
  // dv holds the multiplicand or the divisor magnitude.
  logic [W:0]     madd;
  logic [W:0]     shl;
  logic [W:0]     dif;
  logic [W-1:0]   hi_n, lo_n;
  logic [W-1:0]   fin;

  always_comb begin
    madd = {1'b0, hi_q} + {1'b0, (lo_q[0] ? dv_q : '0)};
    shl  = {hi_q, lo_q[W-1]};
    dif  = shl - {1'b0, dv_q};
    hi_n = hi_q;
    lo_n = lo_q;
    if (!op_q[2]) begin
      hi_n = madd[W:1];
      lo_n = {madd[0], lo_q[W-1:1]};
    end else if (!dif[W]) begin
      hi_n = dif[W-1:0];
      lo_n = {lo_q[W-2:0], 1'b1};
    end else begin
      hi_n = shl[W-1:0];
      lo_n = {lo_q[W-2:0], 1'b0};
    end
  end

  // Result of the last iteration. A zero divisor
  // leaves the dividend as remainder, so only the
  // quotient needs overriding. The signed overflow
  // case falls out of the magnitude arithmetic.
  always_comb begin
    fin = '0;
    case (op_q)
      3'b000: fin = lo_n;
      3'b001: fin = hi_n;
      3'b100,
      3'b101: begin
        if (dv_q == '0) fin = '1;
        else if (qneg_q) fin = -lo_n;
        else fin = lo_n;
      end
      3'b110,
      3'b111: fin = rneg_q ? -hi_n : hi_n;
      default: fin = '0;
    endcase
  end

  logic         sgn, sa, sb;
  logic [W-1:0] am, bm;
  logic         zc;

  always_comb begin
    sgn = op[2] & ~op[0];
    sa  = sgn & a[W-1];
    sb  = sgn & b[W-1];
    am  = sa ? -a : a;
    bm  = sb ? -b : b;
    zc  = (op[2] && b == '0) ||
          (op[2:1] == 2'b00 && (a == '0 || b == '0));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dv_d    = dv_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          cnt_d   = '0;
          hi_d    = '0;
          qneg_d  = sa ^ sb;
          rneg_d  = sa;
          state_d = S_CALC;
          if (op[2]) begin
            lo_d = am;
            dv_d = bm;
          end else begin
            lo_d = b;
            dv_d = a;
          end
`ifdef MDU_ZERO_BYPASS_EN
          if (zc) begin
            state_d = S_DONE;
            if (!op[2]) res_d = '0;
            else if (op[1]) res_d = a;
            else res_d = '1;
          end
`endif
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        hi_d  = hi_n;
        lo_d  = lo_n;
        if (cnt_q == 5'd31) begin
          res_d   = fin;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifndef MDU_ZERO_BYPASS_EN
  logic zc_unused;
  assign zc_unused = zc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dv_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dv_q    <= dv_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = res_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: vector table plus scoreboard for mdu_iter,
// with hand sequences for backpressure and mid-op reset.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

`ifdef MDU_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  mdu_iter #(.XLEN(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] sbq[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[18];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit zcase(logic [2:0] o, logic [31:0] x,
                               logic [31:0] y);
    return (o[2] && y == 0) ||
           (o[2:1] == 2'b00 && (x == 0 || y == 0));
  endfunction

  task automatic pop_chk(string nm);
    logic [31:0] e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got empty scoreboard want entry", nm);
    end else begin
      e = sbq.pop_front();
      chk(nm, result, e);
    end
  endtask

  // Issue one op with out_ready high and check result,
  // latency, in_ready low while busy, and re-ready.
  task automatic run(string nm, logic [2:0] o, logic [31:0] x,
                     logic [31:0] y, logic [31:0] exp);
    int lat;
    int elat;
    bit irb;
    elat = (BYP && zcase(o, x, y)) ? 1 : 33;
    @(negedge clk);
    chk({nm, "_inrdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    sbq.push_back(exp);
    @(posedge clk);
    lat = 0;
    irb = 1'b0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_valid = 1'b0;
        a = ~x;
        b = ~y;
      end
      if (in_ready) irb = 1'b1;
      if (out_valid) lat = c;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_busyrdy"}, 32'(irb), 32'd0);
    pop_chk({nm, "_res"});
    @(negedge clk);
    chk({nm, "_rerdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] x, y, e;
    logic [63:0] p;
    logic [2:0]  o;
    bit          vb;
    int          n;

    vt[0]  = '{3'b000, 32'd7, 32'd6, 32'd42};
    vt[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vt[2]  = '{3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
    vt[3]  = '{3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
    vt[4]  = '{3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF};
    vt[5]  = '{3'b111, 32'd100, 32'd0, 32'd100};
    vt[6]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vt[7]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    vt[8]  = '{3'b000, 32'd0, 32'd5, 32'd0};
    vt[9]  = '{3'b010, 32'd5, 32'd3, 32'd0};
    vt[10] = '{3'b101, 32'd100, 32'd7, 32'd14};
    vt[11] = '{3'b111, 32'd100, 32'd7, 32'd2};
    vt[12] = '{3'b000, 32'h1234_5678, 32'h10, 32'h2345_6780};
    vt[13] = '{3'b001, 32'h8000_0000, 32'd4, 32'd2};
    vt[14] = '{3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vt[15] = '{3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1};
    vt[16] = '{3'b100, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
    vt[17] = '{3'b110, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};

    #12;
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++)
      run($sformatf("v%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].exp);

    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      y = $urandom | 32'd1;
      case (i % 4)
        0: o = 3'b000;
        1: o = 3'b001;
        2: o = 3'b101;
        default: o = 3'b111;
      endcase
      p = {32'd0, x} * {32'd0, y};
      case (o)
        3'b000: e = p[31:0];
        3'b001: e = p[63:32];
        3'b101: e = x / y;
        default: e = x % y;
      endcase
      run($sformatf("r%0d", i), o, x, y, e);
    end

    // Backpressure: hold DONE for 10 cycles.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 3'b101;
    a = 32'd100;
    b = 32'd7;
    sbq.push_back(32'd14);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    pop_chk("bp_res");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = k[0];
      op = 3'b000;
      a = 32'd1;
      b = 32'd1;
      chk("bp_hold", result, 32'd14);
      chk("bp_inrdy", 32'(in_ready), 32'd0);
      chk("bp_ovalid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rerdy", 32'(in_ready), 32'd1);
    chk("bp_drop", 32'(out_valid), 32'd0);
    vb = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) vb = 1'b1;
    end
    chk("bp_ignored", 32'(vb), 32'd0);

    // Reset during CALC discards the op.
    @(negedge clk);
    in_valid = 1'b1;
    op = 3'b101;
    a = 32'd1000;
    b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ovalid", 32'(out_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_result", result, 32'd0);
    chk("mid_inrdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst_mul", 3'b000, 32'd3, 32'd5, 32'd15);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the RV32 core's execute stage. It consumes the two 32-bit operands delivered by the ALU operand select muxes and returns one 32-bit result. Multiplication uses shift-add and division uses restoring shift-subtract, one bit per clock. Handshakes are valid/ready on both sides, so the pipeline stalls while the unit is busy.

## Interface
Parameters:
- `XLEN`, 32 — operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `in_valid`  in  1  — operands and op valid.
- `in_ready`  out  1  — unit can accept; high only in IDLE.
- `op`  in  3  — 000 MUL (low 32), 001 MULHU (high 32, unsigned), 100 DIV, 101 DIVU, 110 REM, 111 REMU; 010/011 reserved.
- `a`  in  32  — rs1 operand / dividend.
- `b`  in  32  — rs2 operand / divisor.
- `out_valid`  out  1  — result valid.
- `out_ready`  in  1  — downstream accepts result.
- `result`  out  32  — result, stable while `out_valid`.
- `busy`  out  1  — high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch `op`/`a`/`b` (signed ops latch magnitudes plus sign flags) and clear the 5-bit counter `cnt`. Go to CALC.
- CALC: one iteration per cycle; `cnt` increments each cycle.
  - After the cycle with `cnt`==31, the final result is registered into `result` and the state goes to DONE.
  - Multiply: 64-bit product accumulator; MUL returns [31:0], MULHU returns [63:32].
  - Divide: 33-bit partial remainder with restoring subtract.
  - Signed DIV/REM: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Special cases, resolved at the final register step:
  - b==0: quotient = 32'hFFFF_FFFF; remainder = a.
  - DIV/REM with a==32'h8000_0000 and b==32'hFFFF_FFFF: quotient = 32'h8000_0000; remainder = 0.
- DONE: `out_valid`=1. On `out_ready`, go to IDLE. Otherwise hold `result` unchanged.
- Reserved op codes are accepted and produce `result`=0 with normal latency.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0, `cnt`=0.

## Timing
- Handshake cycle = cycle 0.
- CALC occupies cycles 1–32. `out_valid` is first high in cycle 33.
- `in_ready` is low from cycle 1 until the cycle after the output handshake. Minimum issue interval is 34 cycles.
- `in_valid` is ignored outside IDLE; no inputs are sampled after acceptance.
- `out_ready` may be held high in advance; the output handshake completes in the first DONE cycle.
- `out_ready` is ignored when `out_valid`=0.
- Asserting `rst_n` low at any time (including mid-CALC or in DONE) immediately forces the reset values. The in-flight operation is discarded and no result is emitted.

## Configuration
- `MDU_ZERO_BYPASS_EN` defined:
  - For divide ops with b==0, or multiply ops with a==0 or b==0, the unit goes IDLE→DONE directly.
  - `out_valid` is high in cycle 1 with the special-case value above (0 for multiply).
- Not defined: these cases take the full 33-cycle latency and give identical result values.

## Test plan
- MUL a=7, b=6 -> `result`=42, `out_valid` rises in cycle 33; `in_ready` low in cycles 1–33.
- MULHU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> `result`=32'hFFFF_FFFE. Then DIV a=-7 (32'hFFFF_FFF9), b=2 -> `result`=32'hFFFF_FFFD. Then REM with the same operands -> 32'hFFFF_FFFF.
- DIVU a=100, b=0 -> 32'hFFFF_FFFF; REMU a=100, b=0 -> 100. Cycle 33 without `MDU_ZERO_BYPASS_EN`, cycle 1 with it.
- DIV a=32'h8000_0000, b=32'hFFFF_FFFF -> 32'h8000_0000; REM with the same operands -> 0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE -> `result` stable, `in_ready`=0, `in_valid` pulses ignored. After `out_ready`=1, `in_ready`=1 in the following cycle.
- Drive `rst_n` low in cycle 15 of a DIVU -> `out_valid`=0, `busy`=0, `result`=0 immediately. After release, a new MUL 3×5 returns 15.
